// File: rtl/spmv_fp16_pkg.sv
// Shared FP16 definitions for the SpMV reduction datapath.
// Field layout, saturation constants, accumulator FSM encodings and operand sanitising.
package spmv_fp16_pkg;

    localparam int unsigned FP16_W         = 16;
    localparam int unsigned EXP_W          = 5;
    localparam int unsigned MANT_W         = 10;
    localparam int unsigned SIG_W          = 14;
    localparam int unsigned SIGN_BIT       = 15;
    localparam int unsigned EXP_MSB        = 14;
    localparam int unsigned EXP_LSB        = 10;
    localparam int unsigned MANT_MSB       = 9;
    localparam int unsigned EXP_BIAS       = 15;
    localparam int unsigned EXP_MAX_FINITE = 30;

    localparam logic [FP16_W-1:0] FP16_POS_MAX = 16'h7BFF;
    localparam logic [FP16_W-1:0] FP16_NEG_MAX = 16'hFBFF;

    localparam logic [0:0] S_ACC = 1'b0;
    localparam logic [0:0] S_OUT = 1'b1;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  expo;
        logic [MANT_W-1:0] mant;
    } fp16_t;

    // Denormals flush to +0; Inf/NaN clamp to max finite with their sign.
    function automatic fp16_t fp16_sanitize(input logic [FP16_W-1:0] x);
        fp16_t f;
        f = fp16_t'(x);
        if (f.expo == '0) begin
            f = fp16_t'(16'h0000);
        end else if (f.expo == '1) begin
            f = f.sign ? fp16_t'(FP16_NEG_MAX) : fp16_t'(FP16_POS_MAX);
        end
        return f;
    endfunction

endpackage

// File: rtl/spmv_fp16_add.sv
// Combinational FP16 adder: flush-to-zero, max-finite saturation, truncating.
// Three guard bits are kept during alignment and dropped after normalisation.
module spmv_fp16_add
    import spmv_fp16_pkg::*;
(
    input  logic [FP16_W-1:0] a_i,
    input  logic [FP16_W-1:0] b_i,
    output logic [FP16_W-1:0] sum_c_o
);

    fp16_t              a_s;
    fp16_t              b_s;
    fp16_t              op_hi;
    fp16_t              op_lo;
    logic [SIG_W-1:0]   sig_hi;
    logic [SIG_W-1:0]   sig_lo;
    logic [SIG_W-1:0]   lo_sh;
    logic [EXP_W-1:0]   exp_diff;
    logic [SIG_W:0]     sum_ext;
    logic [3:0]         lzc;
    logic signed [6:0]  exp_n;
    logic [MANT_W-1:0]  mant_n;

    function automatic logic [3:0] lzc14(input logic [SIG_W-1:0] v);
        logic [3:0] n;
        n = 4'd14;
        for (int i = 0; i < 14; i++) begin
            if (v[i]) n = 4'(13 - i);
        end
        return n;
    endfunction

    always_comb begin
        a_s     = fp16_sanitize(a_i);
        b_s     = fp16_sanitize(b_i);
        op_hi   = a_s;
        op_lo   = b_s;
        sum_c_o = 16'h0000;
        exp_n   = '0;
        mant_n  = '0;

        // Larger magnitude drives sign and exponent of the result.
        if ({b_s.expo, b_s.mant} > {a_s.expo, a_s.mant}) begin
            op_hi = b_s;
            op_lo = a_s;
        end

        sig_hi   = (op_hi.expo != '0) ? {1'b1, op_hi.mant, 3'b000} : '0;
        sig_lo   = (op_lo.expo != '0) ? {1'b1, op_lo.mant, 3'b000} : '0;
        exp_diff = op_hi.expo - op_lo.expo;
        lo_sh    = (exp_diff >= 5'd14) ? '0 : (sig_lo >> exp_diff);

        if (op_hi.sign == op_lo.sign) begin
            sum_ext = {1'b0, sig_hi} + {1'b0, lo_sh};
        end else begin
            sum_ext = {1'b0, sig_hi - lo_sh};
        end

        lzc = lzc14(sum_ext[SIG_W-1:0]);

        if (sum_ext != '0) begin
            if (sum_ext[SIG_W]) begin
                exp_n  = 7'(op_hi.expo) + 7'd1;
                mant_n = sum_ext[SIG_W-1:4];
            end else begin
                exp_n  = 7'(op_hi.expo) - 7'(lzc);
                mant_n = 10'((sum_ext[SIG_W-1:0] << lzc) >> 3);
            end

            if (exp_n < 7'sd1) begin
                sum_c_o = 16'h0000;
            end else if (exp_n > 7'sd30) begin
                sum_c_o = op_hi.sign ? FP16_NEG_MAX : FP16_POS_MAX;
            end else begin
                sum_c_o = {op_hi.sign, exp_n[EXP_W-1:0], mant_n};
            end
        end
    end

endmodule

// File: rtl/spmv_fp16_row_acc.sv
// Per-row FP16 accumulator: sums product beats and emits one indexed result per row
// over valid/ready, holding the result (and stalling input) until it is taken.
module spmv_fp16_row_acc
    import spmv_fp16_pkg::*;
#(
    parameter int unsigned ROW_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [15:0]       i_prod,
    input  logic              i_last,
    input  logic              i_empty,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [15:0]       o_result,
    output logic [ROW_W-1:0]  o_row
);

    logic [0:0]        state_q, state_d;
    logic [15:0]       acc_q, acc_d;
    logic [15:0]       result_q, result_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ROW_W-1:0]  row_cnt_q, row_cnt_d;
    logic [15:0]       sum_c;
    logic              accept_c;

    spmv_fp16_add u_add (
        .a_i     (acc_q),
        .b_i     (i_prod),
        .sum_c_o (sum_c)
    );

    assign o_ready  = (state_q == S_ACC) || i_ready;
    assign accept_c = i_valid && o_ready;
    assign o_valid  = (state_q == S_OUT);
    assign o_result = result_q;
    assign o_row    = row_q;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q   <= S_ACC;
            acc_q     <= 16'h0000;
            result_q  <= 16'h0000;
            row_q     <= '0;
            row_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            result_q  <= result_d;
            row_q     <= row_d;
            row_cnt_q <= row_cnt_d;
        end
    end

    // A last beat loads a fresh result even while the previous one is being drained.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        result_d  = result_q;
        row_d     = row_q;
        row_cnt_d = row_cnt_q;

        if (accept_c && i_last) begin
            acc_d     = 16'h0000;
            result_d  = i_empty ? 16'h0000 : sum_c;
            row_d     = row_cnt_q;
            row_cnt_d = row_cnt_q + ROW_W'(1);
            state_d   = S_OUT;
        end else begin
            if (accept_c) begin
                acc_d = sum_c;
            end
            if ((state_q == S_OUT) && i_ready) begin
                state_d = S_ACC;
            end
        end
    end

endmodule
